// File: rtl/counter_timer_pkg.sv
// Shared constants for the multi-channel counter/timer: modes, register map, field positions.
package counter_timer_pkg;

    // Channel operating modes (CTRL bits 2:1)
    typedef enum logic [1:0] {
        ONESHOT  = 2'd0,
        PERIODIC = 2'd1,
        PWM      = 2'd2,
        FREE     = 2'd3
    } mode_e;

    // Bus address layout: {channel[2:0], reg[1:0]}
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned CH_IDX_W = 3;

    // Per-channel register offsets
    localparam logic [1:0] REG_RELOAD  = 2'd0;
    localparam logic [1:0] REG_CTRL    = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_COMPARE = 2'd3;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_MODE_LSB  = 1;
    localparam int unsigned CTRL_IRQ_EN    = 3;
    localparam int unsigned STATUS_PENDING = 0;

endpackage

// File: rtl/counter_timer_array_if.sv
// Word-addressed register port between the bus decoder and the timer array.
interface counter_timer_array_if #(
    parameter int unsigned WIDTH = 32
);
    import counter_timer_pkg::*;

    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [WIDTH-1:0]  bus_wdata;
    logic [WIDTH-1:0]  bus_rdata;

    modport master (
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/counter_timer_channel.sv
// One timer channel: source synchroniser, edge detect, counter, mode logic and pending flag.
module counter_timer_channel
    import counter_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_clk,
    input  logic             wr_reload,
    input  logic             wr_ctrl,
    input  logic             wr_status,
    input  logic             wr_compare,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] compare,
    output logic             en,
    output mode_e            mode,
    output logic             irq_en,
    output logic             pending,
    output logic             ch_out
);

    logic [1:0]       sync_q;
    logic             src_prev;
    logic             step;
    logic [WIDTH-1:0] reload;
    logic             out_q;
    logic [WIDTH-1:0] count_next;
    logic             fire;
    logic             step_hit;
    logic             pend_set;
    logic             pend_clr;

    // Two-flop synchroniser followed by a registered rising-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b00;
            src_prev <= 1'b0;
            step     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], src_clk};
            src_prev <= sync_q[1];
            step     <= sync_q[1] & ~src_prev;
        end
    end

    // Next count value and terminal-event detection for the current mode
    always_comb begin
        count_next = count;
        fire       = 1'b0;
        case (mode)
            ONESHOT: begin
                if (count == '0) fire = 1'b1;
                else             count_next = count - WIDTH'(1);
            end
            PERIODIC, PWM: begin
                if (count == '0) begin
                    fire       = 1'b1;
                    count_next = reload;
                end else begin
                    count_next = count - WIDTH'(1);
                end
            end
            FREE: begin
                count_next = count + WIDTH'(1);
                fire       = (count == '1);
            end
            default: begin
                count_next = count;
                fire       = 1'b0;
            end
        endcase
    end

    // A CTRL write restarts the channel and discards any coincident step
    assign step_hit = en & step & ~wr_ctrl;
    assign pend_set = step_hit & fire;
    assign pend_clr = wr_status & wdata[STATUS_PENDING];

    // Register file, counter and mode output state
    always_ff @(posedge clk) begin
        if (rst) begin
            reload  <= '0;
            compare <= '0;
            count   <= '0;
            en      <= 1'b0;
            mode    <= ONESHOT;
            irq_en  <= 1'b0;
            pending <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            if (wr_reload)  reload  <= wdata;
            if (wr_compare) compare <= wdata;
            if (wr_ctrl) begin
                en     <= wdata[CTRL_EN];
                mode   <= mode_e'(wdata[CTRL_MODE_LSB +: 2]);
                irq_en <= wdata[CTRL_IRQ_EN];
                if (wdata[CTRL_EN]) begin
                    count <= reload;
                    out_q <= 1'b0;
                end
            end else if (step_hit) begin
                count <= count_next;
                if (fire) begin
                    if (mode == ONESHOT) begin
                        out_q <= 1'b1;
                        en    <= 1'b0;
                    end else begin
                        out_q <= ~out_q;
                    end
                end
            end
            // Set beats a simultaneous write-1-to-clear
            pending <= pend_set | (pending & ~pend_clr);
        end
    end

    // Mode output: PWM and FREE derive directly from the registered count
    always_comb begin
        case (mode)
            PWM:     ch_out = (count < compare);
            FREE:    ch_out = count[WIDTH-1];
            default: ch_out = out_q;
        endcase
    end

endmodule

// File: rtl/counter_timer_array.sv
// Multi-channel timer/counter: address decode, registered read mux and interrupt combine.
module counter_timer_array
    import counter_timer_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   src_clk,
    counter_timer_array_if.slave  bus,
    output logic [CHANNELS-1:0]   ch_out,
    output logic                  irq
);

    logic [CH_IDX_W-1:0] ch_sel;
    logic [1:0]          reg_sel;
    logic [WIDTH-1:0]    rd_word;

    logic [WIDTH-1:0]    count   [CHANNELS];
    logic [WIDTH-1:0]    compare [CHANNELS];
    mode_e               mode    [CHANNELS];
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] irq_en;
    logic [CHANNELS-1:0] pending;

    assign ch_sel  = bus.bus_addr[ADDR_W-1:2];
    assign reg_sel = bus.bus_addr[1:0];

    // Channel instances; out-of-range channel indices never match a write strobe
    for (genvar gi = 0; gi < int'(CHANNELS); gi++) begin : g_ch
        logic hit;
        assign hit = bus.bus_we && (ch_sel == CH_IDX_W'(gi));

        counter_timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .src_clk    (src_clk[gi]),
            .wr_reload  (hit && (reg_sel == REG_RELOAD)),
            .wr_ctrl    (hit && (reg_sel == REG_CTRL)),
            .wr_status  (hit && (reg_sel == REG_STATUS)),
            .wr_compare (hit && (reg_sel == REG_COMPARE)),
            .wdata      (bus.bus_wdata),
            .count      (count[gi]),
            .compare    (compare[gi]),
            .en         (en[gi]),
            .mode       (mode[gi]),
            .irq_en     (irq_en[gi]),
            .pending    (pending[gi]),
            .ch_out     (ch_out[gi])
        );
    end

    // Read mux; unmapped channels read as zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (ch_sel == CH_IDX_W'(i)) begin
                case (reg_sel)
                    REG_RELOAD:  rd_word = count[i];
                    REG_CTRL:    rd_word = WIDTH'({irq_en[i], mode[i], en[i]});
                    REG_STATUS:  rd_word = WIDTH'(pending[i]);
                    REG_COMPARE: rd_word = compare[i];
                    default:     rd_word = '0;
                endcase
            end
        end
    end

    // Read data registered one cycle after the address
    always_ff @(posedge clk) begin
        if (rst) bus.bus_rdata <= '0;
        else     bus.bus_rdata <= rd_word;
    end

    assign irq = |(pending & irq_en);

endmodule

// File: tb/tb_counter_timer_array.sv
// Self-checking bench for counter_timer_array with closed-form per-mode expectations.
module tb_counter_timer_array;
    import counter_timer_pkg::*;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] src_clk;
    logic [CH-1:0] ch_out;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    counter_timer_array_if #(.WIDTH(W)) bus ();

    counter_timer_array #(
        .CHANNELS (CH),
        .WIDTH    (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .src_clk (src_clk),
        .bus     (bus),
        .ch_out  (ch_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int r, input logic [W-1:0] d);
        bus.bus_we    = 1'b1;
        bus.bus_addr  = {3'(ch), 2'(r)};
        bus.bus_wdata = d;
        tick();
        bus.bus_we    = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, output logic [W-1:0] d);
        bus.bus_addr = {3'(ch), 2'(r)};
        tick();
        d = bus.bus_rdata;
    endtask

    task automatic pulse(input int ch);
        src_clk[ch] = 1'b1;
        repeat (4) tick();
        src_clk[ch] = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [W-1:0] ctrl_word(input bit e, input mode_e m, input bit ie);
        return W'({ie, m, e});
    endfunction

    task automatic test_reset();
        logic [W-1:0] v;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n_checks++;
        if (ch_out !== '0 || irq !== 1'b0 || bus.bus_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ch_out=%0h irq=%0b rdata=%0h required 0/0/0", ch_out, irq, bus.bus_rdata);
        end
        for (int c = 0; c < int'(CH); c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(c, r, v);
                n_checks++;
                if (v !== '0) begin
                    n_fail++;
                    $display("FAIL reset_reg ch%0d reg%0d: got %0h required 0", c, r, v);
                end
            end
        end
    endtask

    task automatic test_periodic();
        logic [W-1:0] v;
        int rl, cyc, exp_cnt;
        bit exp_out, exp_pend;
        for (int round = 0; round < 2; round++) begin
            rl  = (round == 0) ? 3 : int'($urandom_range(0, 6));
            cyc = rl + 1;
            wr(0, 0, W'(rl));
            wr(0, 1, ctrl_word(1'b1, PERIODIC, 1'b1));
            wr(0, 2, W'(1));
            for (int k = 1; k <= 2 * cyc + 1; k++) begin
                pulse(0);
                exp_cnt  = rl - (k % cyc);
                exp_out  = ((k / cyc) % 2) == 1;
                exp_pend = (k >= cyc);
                rd(0, 0, v);
                n_checks++;
                if (v !== W'(exp_cnt) || ch_out[0] !== exp_out || irq !== exp_pend) begin
                    n_fail++;
                    $display("FAIL periodic rl=%0d step%0d: count=%0d out=%0b irq=%0b required %0d/%0b/%0b",
                             rl, k, v, ch_out[0], irq, exp_cnt, exp_out, exp_pend);
                end
            end
            wr(0, 2, W'(1));
            rd(0, 2, v);
            n_checks++;
            if (irq !== 1'b0 || v !== '0) begin
                n_fail++;
                $display("FAIL periodic_w1c: irq=%0b pending=%0h required 0/0", irq, v);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [W-1:0] v, c;
        int rl;
        bit fired;
        for (int round = 0; round < 2; round++) begin
            rl = (round == 0) ? 2 : int'($urandom_range(0, 4));
            wr(1, 2, W'(1));
            wr(1, 0, W'(rl));
            wr(1, 1, ctrl_word(1'b1, ONESHOT, 1'b0));
            rd(1, 0, v);
            n_checks++;
            if (v !== W'(rl) || ch_out[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL oneshot_load: count=%0d out=%0b required %0d/0", v, ch_out[1], rl);
            end
            for (int k = 1; k <= rl + 3; k++) begin
                pulse(1);
                fired = (k >= rl + 1);
                rd(1, 0, v);
                rd(1, 1, c);
                n_checks++;
                if (v !== (fired ? W'(0) : W'(rl - k)) || ch_out[1] !== fired ||
                    c[0] !== !fired || dut.pending[1] !== fired) begin
                    n_fail++;
                    $display("FAIL oneshot rl=%0d step%0d: count=%0d out=%0b en=%0b required %0d/%0b/%0b",
                             rl, k, v, ch_out[1], c[0], fired ? 0 : rl - k, fired, !fired);
                end
            end
        end
    endtask

    task automatic test_pwm();
        logic [W-1:0] v;
        int rl, cmp, cnt, highs;
        bit exp_out;
        rl = 9; cmp = 3; highs = 0;
        wr(2, 0, W'(rl));
        wr(2, 3, W'(cmp));
        wr(2, 1, ctrl_word(1'b1, PWM, 1'b0));
        for (int k = 1; k <= 20; k++) begin
            pulse(2);
            cnt     = rl - (k % (rl + 1));
            exp_out = (cnt < cmp);
            if (ch_out[2] === 1'b1) highs++;
            n_checks++;
            if (ch_out[2] !== exp_out) begin
                n_fail++;
                $display("FAIL pwm step%0d: out=%0b required %0b", k, ch_out[2], exp_out);
            end
        end
        n_checks++;
        if (highs != 6) begin
            n_fail++;
            $display("FAIL pwm_duty: high steps=%0d required 6", highs);
        end
        wr(2, 3, W'(0));
        for (int k = 0; k < 10; k++) begin
            pulse(2);
            n_checks++;
            if (ch_out[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL pwm_cmp0 step%0d: out=%0b required 0", k, ch_out[2]);
            end
        end
        rl  = int'($urandom_range(1, 8));
        cmp = int'($urandom_range(0, 12));
        wr(2, 0, W'(rl));
        wr(2, 3, W'(cmp));
        wr(2, 1, ctrl_word(1'b1, PWM, 1'b0));
        for (int k = 1; k <= 2 * (rl + 1); k++) begin
            pulse(2);
            cnt = rl - (k % (rl + 1));
            rd(2, 0, v);
            n_checks++;
            if (v !== W'(cnt) || ch_out[2] !== (cnt < cmp)) begin
                n_fail++;
                $display("FAIL pwm_rand rl=%0d cmp=%0d step%0d: count=%0d out=%0b required %0d/%0b",
                         rl, cmp, k, v, ch_out[2], cnt, cnt < cmp);
            end
        end
    endtask

    task automatic test_free();
        logic [W-1:0] v, p;
        int n;
        wr(3, 0, W'(250));
        wr(3, 1, ctrl_word(1'b1, FREE, 1'b0));
        for (int k = 0; k < 5; k++) pulse(3);
        rd(3, 0, v);
        rd(3, 2, p);
        n_checks++;
        if (v !== W'(255) || ch_out[3] !== 1'b1 || p !== '0) begin
            n_fail++;
            $display("FAIL free_top: count=%0d out=%0b pending=%0h required 255/1/0", v, ch_out[3], p);
        end
        // Wrap step lands on the same edge as a write-1-to-clear
        src_clk[3] = 1'b1;
        repeat (3) tick();
        bus.bus_we    = 1'b1;
        bus.bus_addr  = {3'd3, 2'd2};
        bus.bus_wdata = W'(1);
        tick();
        bus.bus_we = 1'b0;
        src_clk[3] = 1'b0;
        repeat (3) tick();
        rd(3, 2, p);
        rd(3, 0, v);
        n_checks++;
        if (p !== W'(1) || v !== '0 || ch_out[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL free_wrap_w1c: pending=%0h count=%0d out=%0b required 1/0/0", p, v, ch_out[3]);
        end
        n = int'($urandom_range(1, 20));
        for (int k = 0; k < n; k++) pulse(3);
        rd(3, 0, v);
        n_checks++;
        if (v !== W'(n % 256)) begin
            n_fail++;
            $display("FAIL free_count after %0d steps: count=%0d required %0d", n, v, n % 256);
        end
    endtask

    task automatic test_invalid_channel();
        logic [W-1:0] v, c3_before, c0_before, cmp_before, after;
        logic irq_before;
        rd(3, 0, c3_before);
        rd(0, 1, c0_before);
        rd(2, 3, cmp_before);
        irq_before = irq;
        for (int ch = 5; ch < 8; ch++) begin
            for (int r = 0; r < 4; r++) wr(ch, r, W'($urandom_range(1, 255)));
        end
        for (int ch = 5; ch < 8; ch++) begin
            for (int r = 0; r < 4; r++) begin
                rd(ch, r, v);
                n_checks++;
                if (v !== '0) begin
                    n_fail++;
                    $display("FAIL invalid_read ch%0d reg%0d: got %0h required 0", ch, r, v);
                end
            end
        end
        rd(3, 0, after);
        n_checks++;
        if (after !== c3_before) begin
            n_fail++;
            $display("FAIL invalid_ch3_count: got %0h required %0h", after, c3_before);
        end
        rd(0, 1, after);
        n_checks++;
        if (after !== c0_before || irq !== irq_before) begin
            n_fail++;
            $display("FAIL invalid_ch0_ctrl: got %0h irq=%0b required %0h irq=%0b", after, irq, c0_before, irq_before);
        end
        rd(2, 3, after);
        n_checks++;
        if (after !== cmp_before) begin
            n_fail++;
            $display("FAIL invalid_ch2_compare: got %0h required %0h", after, cmp_before);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [W-1:0] v;
        wr(0, 0, W'(1));
        wr(0, 1, ctrl_word(1'b1, PERIODIC, 1'b1));
        for (int k = 0; k < 3; k++) pulse(0);
        rd(0, 0, v);
        n_checks++;
        if (irq !== 1'b1 || ch_out === '0) begin
            n_fail++;
            $display("FAIL pre_reset: irq=%0b ch_out=%0h required irq=1 and ch_out nonzero", irq, ch_out);
        end
        src_clk[0] = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (ch_out !== '0 || irq !== 1'b0 || bus.bus_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: ch_out=%0h irq=%0b rdata=%0h required 0/0/0", ch_out, irq, bus.bus_rdata);
        end
        rst = 1'b0;
        src_clk[0] = 1'b0;
        repeat (4) tick();
        rd(0, 0, v);
        n_checks++;
        if (v !== '0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after: count=%0d irq=%0b required 0/0", v, irq);
        end
    endtask

    initial begin
        rst           = 1'b1;
        src_clk       = '0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_pwm();
        test_free();
        test_invalid_channel();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
